// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing defaults, counter widths and sync-decoder state encoding
package vga_timing_pkg;

  localparam int HCLK_W = 12;
  localparam int LINE_W = 10;

  localparam int DEF_CLK_PER_PIXEL = 4;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BACK        = 48;
  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_H_TOTAL       = 800;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BACK        = 33;
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_V_TOTAL       = 525;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_t;

  function automatic logic [HCLK_W-1:0] sat_inc(input logic [HCLK_W-1:0] v);
    return (&v) ? v : v + HCLK_W'(1);
  endfunction

endpackage

// File: rtl/vga_sync_sync.sv
// rtl/vga_sync_sync.sv - double-flop synchroniser for an active-low sync line with leading-edge detect
module vga_sync_sync (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = sync_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Idle sync is high, so reset to 1 to avoid a false leading edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel coordinates, lock state and frame checksum from a VGA stream
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int CLK_PER_PIXEL = DEF_CLK_PER_PIXEL,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_BACK        = DEF_H_BACK,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int H_TOTAL       = DEF_H_TOTAL,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_BACK        = DEF_V_BACK,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int V_TOTAL       = DEF_V_TOTAL
) (
  input  logic        CLK_100MHz,
  input  logic        Reset,
  input  logic        HSync,
  input  logic        VSync,
  input  logic [2:0]  Red,
  input  logic [2:0]  Green,
  input  logic [1:0]  Blue,
  output logic        PixelValid,
  output logic [9:0]  PixelX,
  output logic [9:0]  PixelY,
  output logic [7:0]  PixelColor,
  output logic        Locked,
  output logic        SyncError,
  output logic        FrameDone,
  output logic [15:0] FrameChecksum
);

  localparam int HCLK_LINE = H_TOTAL * CLK_PER_PIXEL;
  localparam int X_OFF     = H_SYNC + H_BACK;
  localparam int Y_OFF     = V_SYNC + V_BACK;

  logic hs_fall, vs_fall;

  vga_sync_sync u_hsync (.clk(CLK_100MHz), .reset(Reset), .sync_in(HSync), .fall(hs_fall));
  vga_sync_sync u_vsync (.clk(CLK_100MHz), .reset(Reset), .sync_in(VSync), .fall(vs_fall));

  logic [7:0]        col1_q, col1_d, col2_q, col2_d, col3_q, col3_d;
  logic [HCLK_W-1:0] hclk_q, hclk_d;
  logic [LINE_W-1:0] line_q, line_d;
  sync_state_t       state_q, state_d;
  logic              seen_q, seen_d;
  logic [15:0]       acc_q, acc_d, checksum_q, checksum_d;
  logic              sync_error_q, sync_error_d, frame_done_q, frame_done_d;
  logic              pix_valid_q, pix_valid_d;
  logic [9:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]        pix_color_q, pix_color_d;

  logic [HCLK_W-1:0] pix_col;
  logic              sample_tick, x_act, y_act, pix_take;
  logic              len_bad, lines_ok, hclk_max;

  // col3 matches the edge detector's extra delay, so hclk==k lines up with clock k of the line.
  always_comb begin
    col1_d = {Red, Green, Blue};
    col2_d = col1_q;
    col3_d = col2_q;
    hclk_d = hs_fall ? '0 : sat_inc(hclk_q);
    line_d = line_q;
    if (vs_fall)      line_d = '0;
    else if (hs_fall) line_d = line_q + LINE_W'(1);
  end

  always_comb begin
    pix_col     = hclk_q / HCLK_W'(CLK_PER_PIXEL);
    sample_tick = (hclk_q % HCLK_W'(CLK_PER_PIXEL)) == HCLK_W'(CLK_PER_PIXEL / 2);
    x_act       = (pix_col >= HCLK_W'(X_OFF)) && (pix_col < HCLK_W'(X_OFF + H_ACTIVE));
    y_act       = (line_q >= LINE_W'(Y_OFF)) && (line_q < LINE_W'(Y_OFF + V_ACTIVE));
    pix_take    = sample_tick && !hs_fall && x_act && y_act && (state_q == ST_LOCKED);
    pix_valid_d = pix_take;
    pix_x_d     = pix_take ? 10'(pix_col - HCLK_W'(X_OFF)) : '0;
    pix_y_d     = pix_take ? 10'(line_q - LINE_W'(Y_OFF)) : '0;
    pix_color_d = pix_take ? col3_q : '0;
    len_bad     = hs_fall && seen_q && (({1'b0, hclk_q} + 13'd1) != 13'(HCLK_LINE));
    lines_ok    = ({1'b0, line_q} + 11'd1) == 11'(V_TOTAL);
    hclk_max    = &hclk_q;
  end

  // The HSync edge that coincides with VSync is the first of the new frame.
  always_comb begin
    state_d      = state_q;
    seen_d       = vs_fall ? hs_fall : (seen_q | hs_fall);
    sync_error_d = 1'b0;
    frame_done_d = 1'b0;
    checksum_d   = checksum_q;
    acc_d        = pix_take ? acc_q + 16'(col3_q) : acc_q;
    case (state_q)
      ST_SEARCH: begin
        acc_d = '0;
        if (vs_fall) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        acc_d = '0;
        if (len_bad)      state_d = ST_SEARCH;
        else if (vs_fall) state_d = lines_ok ? ST_LOCKED : ST_MEASURE;
      end
      ST_LOCKED: begin
        if (len_bad || (vs_fall && !lines_ok) || hclk_max) begin
          sync_error_d = 1'b1;
          state_d      = ST_SEARCH;
          acc_d        = '0;
        end else if (vs_fall) begin
          frame_done_d = 1'b1;
          checksum_d   = acc_q;
          acc_d        = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      col1_q       <= '0;
      col2_q       <= '0;
      col3_q       <= '0;
      hclk_q       <= '0;
      line_q       <= '0;
      state_q      <= ST_SEARCH;
      seen_q       <= 1'b0;
      acc_q        <= '0;
      checksum_q   <= '0;
      sync_error_q <= 1'b0;
      frame_done_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_color_q  <= '0;
    end else begin
      col1_q       <= col1_d;
      col2_q       <= col2_d;
      col3_q       <= col3_d;
      hclk_q       <= hclk_d;
      line_q       <= line_d;
      state_q      <= state_d;
      seen_q       <= seen_d;
      acc_q        <= acc_d;
      checksum_q   <= checksum_d;
      sync_error_q <= sync_error_d;
      frame_done_q <= frame_done_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
    end
  end

  assign PixelValid    = pix_valid_q;
  assign PixelX        = pix_x_q;
  assign PixelY        = pix_y_q;
  assign PixelColor    = pix_color_q;
  assign Locked        = (state_q == ST_LOCKED);
  assign SyncError     = sync_error_q;
  assign FrameDone     = frame_done_q;
  assign FrameChecksum = checksum_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a reduced 16x8-pixel timing
module tb_vga_sync_decoder;

  localparam int CPP = 4, HS = 2, HB = 2, HA = 8, HT = 16;
  localparam int VS = 1, VB = 2, VA = 4, VT = 8;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        HSync = 1'b1, VSync = 1'b1;
  logic [2:0]  Red = '0, Green = '0;
  logic [1:0]  Blue = '0;
  logic        PixelValid, Locked, SyncError, FrameDone;
  logic [9:0]  PixelX, PixelY;
  logic [7:0]  PixelColor;
  logic [15:0] FrameChecksum;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .CLK_PER_PIXEL(CPP), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .CLK_100MHz(clk), .Reset(Reset), .HSync(HSync), .VSync(VSync),
    .Red(Red), .Green(Green), .Blue(Blue),
    .PixelValid(PixelValid), .PixelX(PixelX), .PixelY(PixelY), .PixelColor(PixelColor),
    .Locked(Locked), .SyncError(SyncError), .FrameDone(FrameDone), .FrameChecksum(FrameChecksum)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [27:0] pix_exp[$];
  logic [15:0] done_exp[$];
  int          err_exp = 0;
  logic        err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_color(input int mode, input int x, input int y);
    case (mode)
      0:       return 8'hFF;
      1:       return 8'(8'h12 + x * 16 + y * 3);
      default: return 8'(x * 7 + y * 29 + 5);
    endcase
  endfunction

  always @(negedge clk) begin
    logic [27:0] pe;
    logic [15:0] de;
    if (PixelValid) begin
      if (pix_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d c=0x%0h expected none", PixelX, PixelY, PixelColor);
      end else begin
        pe = pix_exp.pop_front();
        check("pixel_xyc", {4'h0, PixelX, PixelY, PixelColor}, {4'h0, pe});
      end
    end
    if (FrameDone) begin
      if (done_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_frame_done: got checksum 0x%0h expected no pulse", FrameChecksum);
      end else begin
        de = done_exp.pop_front();
        check("frame_checksum", FrameChecksum, de);
      end
    end
    if (SyncError && !err_prev) begin
      n_checks++;
      if (err_exp > 0) err_exp--;
      else begin
        n_fail++;
        $display("FAIL unexpected_sync_error: got 1 expected 0");
      end
    end
    if (err_prev) begin
      check("locked_after_error", Locked, 0);
      check("sync_error_single_pulse", SyncError, 0);
    end
    err_prev <= SyncError;
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {Locked, PixelValid, SyncError, FrameDone, FrameChecksum}, 0);
    check({name, "_data"}, {PixelX, PixelY, PixelColor}, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    check("locked_before_reset", Locked, 1);
    Reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midframe_reset");
    Reset = 1'b0;
  endtask

  task automatic gen_frame(input int mode, input bit push, input int nlines,
                           input int short_line, input int reset_line, output logic [15:0] chk);
    chk = '0;
    for (int ln = 0; ln < nlines; ln++) begin
      int npix;
      bit push_ln;
      npix    = (ln == short_line) ? HT - 1 : HT;
      push_ln = push && !(short_line >= 0 && ln > short_line) && !(reset_line >= 0 && ln >= reset_line);
      if (ln == reset_line) pulse_reset();
      for (int p = 0; p < npix; p++) begin
        int x, y;
        bit act;
        logic [7:0] c;
        x   = p - (HS + HB);
        y   = ln - (VS + VB);
        act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
        c   = act ? pix_color(mode, x, y) : 8'hA5;
        if (act && push_ln) begin
          pix_exp.push_back({10'(x), 10'(y), c});
          chk = chk + 16'(c);
        end
        for (int k = 0; k < CPP; k++) begin
          @(posedge clk);
          #1;
          HSync = (p >= HS);
          VSync = (ln >= VS);
          {Red, Green, Blue} = c;
        end
      end
    end
  endtask

  task automatic hold_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      HSync = 1'b1;
      VSync = 1'b1;
      {Red, Green, Blue} = 8'h00;
    end
  endtask

  initial begin
    logic [15:0] chk, chk2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    Reset = 1'b0;

    gen_frame(0, 0, VT, -1, -1, chk);
    check("locked_after_first_vsync", Locked, 0);
    gen_frame(0, 1, VT, -1, -1, chk);
    check("locked_after_second_vsync", Locked, 1);
    done_exp.push_back(16'h1FE0);
    gen_frame(1, 1, VT, -1, -1, chk2);
    done_exp.push_back(chk2);

    err_exp++;
    gen_frame(2, 1, VT, 4, -1, chk);
    check("locked_after_short_line", Locked, 0);
    check("checksum_hold_short_line", FrameChecksum, chk2);
    gen_frame(2, 0, VT, -1, -1, chk);
    check("measure_after_short_line", Locked, 0);

    gen_frame(1, 1, 5, -1, -1, chk);
    err_exp++;
    hold_idle(5000);
    check("locked_after_hclk_saturate", Locked, 0);
    check("checksum_hold_saturate", FrameChecksum, chk2);

    gen_frame(2, 0, VT, -1, -1, chk);
    gen_frame(2, 1, VT, -1, 3, chk);
    check("locked_after_reset_frame", Locked, 0);
    gen_frame(2, 0, VT, -1, -1, chk);
    check("relock_needs_two_edges", Locked, 0);
    gen_frame(1, 1, VT, -1, -1, chk);
    check("relocked", Locked, 1);
    done_exp.push_back(chk);
    gen_frame(2, 1, VT, -1, -1, chk);
    hold_idle(20);
    check("locked_final", Locked, 1);

    check("pixels_outstanding", pix_exp.size(), 0);
    check("frame_done_outstanding", done_exp.size(), 0);
    check("sync_error_outstanding", err_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter CLK_PER_PIXEL, 4, clocks per pixel (100 MHz / 25 MHz).
REQ-002 SHALL have parameters H_SYNC 96, H_BACK 48, H_ACTIVE 640, H_TOTAL 800, in pixels.
REQ-003 SHALL have parameters V_SYNC 2, V_BACK 33, V_ACTIVE 480, V_TOTAL 525, in lines.
REQ-004 SHALL have port CLK_100MHz, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have ports HSync, VSync, input, 1 each, active-low sync from the VGA generator.
REQ-007 SHALL have ports Red, input, 3; Green, input, 3; Blue, input, 2: pixel colour.
REQ-008 SHALL have port PixelValid, output, 1: one-cycle strobe per decoded active pixel.
REQ-009 SHALL have ports PixelX, output, 10 and PixelY, output, 10: active-area coordinates.
REQ-010 SHALL have port PixelColor, output, 8: {Red,Green,Blue} of the sampled pixel.
REQ-011 SHALL have ports Locked, output, 1; SyncError, output, 1 (pulse); FrameDone, output, 1 (pulse).
REQ-012 SHALL have port FrameChecksum, output, 16: checksum of the last complete locked frame.

Function
REQ-013 SHALL pass HSync, VSync, Red, Green, Blue through two flop stages each, keeping colour aligned with sync.
REQ-014 SHALL detect sync leading edges as 1->0 transitions on the synchronised signals.
REQ-015 SHALL clear a 12-bit clock counter hclk on every HSync leading edge, else increment, saturating at 4095.
REQ-016 SHALL increment a 10-bit line counter on each HSync leading edge and clear it on a VSync leading edge; both edges in one cycle clear it.
REQ-017 SHALL sample a pixel when hclk mod CLK_PER_PIXEL == CLK_PER_PIXEL/2, pixel column p = hclk/CLK_PER_PIXEL.
REQ-018 SHALL define X = p-(H_SYNC+H_BACK), Y = line-(V_SYNC+V_BACK); the pixel is active when 0<=X<H_ACTIVE and 0<=Y<V_ACTIVE.
REQ-019 SHALL register outputs; PixelValid/X/Y/Color appear 3 cycles after the input sample edge, PixelValid only in LOCKED.
REQ-020 SHALL implement FSM SEARCH, MEASURE, LOCKED; Locked = (state==LOCKED).
REQ-021 SEARCH -> MEASURE on a VSync leading edge.
REQ-022 MEASURE: each HSync leading edge after the first in the frame checks hclk+1 == H_TOTAL*CLK_PER_PIXEL; mismatch -> SEARCH, no SyncError.
REQ-023 MEASURE -> LOCKED on the next VSync leading edge if all lines matched and line count == V_TOTAL, else -> MEASURE (restart).
REQ-024 LOCKED: any line-length mismatch, line count != V_TOTAL at VSync edge, or hclk reaching 4095 SHALL pulse SyncError one cycle and go to SEARCH.
REQ-025 SHALL accumulate a 16-bit modulo-2^16 sum of PixelColor over active pixels while LOCKED.
REQ-026 On each VSync leading edge in LOCKED with a valid frame, SHALL load FrameChecksum, pulse FrameDone one cycle, clear the accumulator.
REQ-027 The first VSync edge entering LOCKED SHALL clear the accumulator but not pulse FrameDone.
REQ-028 On error, FrameChecksum SHALL hold its last value; accumulator clears.

Reset
REQ-029 Reset SHALL force state SEARCH, all counters, flops and accumulator to 0, synchroniser flops to 1 (idle sync).
REQ-030 During/after reset every output SHALL be 0 from the next rising edge; Reset mid-frame discards the frame.

Structure
REQ-031 Timing defaults, FSM state encodings and the counter width constant SHALL live in a shared package vga_timing_pkg, reused by the generator.
REQ-032 The edge-detecting double-flop synchroniser SHALL be one sub-module, vga_sync_sync, instantiated per sync line; colour uses plain flops.

Verification
REQ-033 Ideal 640x480 stream, colour 0xFF -> Locked after 2nd VSync edge; next FrameDone with FrameChecksum 0x5000.
REQ-034 Locked, pixel (0,0) colour 0x12 -> first PixelValid of frame shows X=0, Y=0, PixelColor=0x12.
REQ-035 Locked, one line of 799 pixels -> SyncError single pulse, Locked=0 next cycle, PixelValid stays 0.
REQ-036 Locked, HSync held high 5000 clocks -> SyncError when hclk hits 4095, state SEARCH.
REQ-037 Reset asserted mid-frame while locked -> all outputs 0 next cycle; relock needs two further VSync edges.
REQ-038 Simultaneous HSync/VSync leading edges -> line counter 0, hclk 0, no spurious SyncError.
